hazard_stall_unit: RTL and testbench
====================================

HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 SHALL have parameter MD_LATENCY, default 4, giving the multiply/divide busy cycles; legal range 1..15.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports ID_Rs and ID_Rt, input, `LEN_INST_REG bits each: the source registers of the instruction in ID.
REQ-005 SHALL have ports ID_UsesRt, ID_Branch, ID_ReadsHiLo and ID_MdStart, input, 1 bit each: ID reads Rt / is a branch / reads HI-LO / starts a multiply or divide.
REQ-006 SHALL have ports ID_EX_MemRead and ID_EX_RegWrite, input, 1 bit each, and ID_EX_Rd, input, `LEN_INST_REG bits: the destination in EX.
REQ-007 SHALL have port EX_MEM_MemRead, input, 1 bit, and EX_MEM_Rd, input, `LEN_INST_REG bits: the destination in MEM.
REQ-008 SHALL have port ID_BranchTaken, input, 1 bit: the branch compare in ID resolved taken.
REQ-009 SHALL have ports PCWrite, IF_ID_Write, ID_EX_Bubble and IF_ID_Flush, output, 1 bit each.
REQ-010 SHALL have port MdBusy, output, 1 bit: the multiply/divide countdown is nonzero.

Function
REQ-011 Matches are defined as follows: a destination register X "matches" when X != 0 and (X == ID_Rs, or ID_UsesRt and X == ID_Rt).
REQ-012 load_use SHALL be true when ID_EX_MemRead is 1 and ID_EX_Rd matches.
REQ-013 br_hazard SHALL be true when ID_Branch is 1 and either (ID_EX_RegWrite is 1 and ID_EX_Rd matches) or (EX_MEM_MemRead is 1 and EX_MEM_Rd matches); a load feeding a branch therefore stalls 2 cycles.
REQ-014 md_hazard SHALL be true when MdBusy is 1 and either ID_ReadsHiLo or ID_MdStart is 1.
REQ-015 stall = load_use | br_hazard | md_hazard, evaluated combinationally in the same cycle.
REQ-016 While stall is 1: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0.
REQ-017 While stall is 0: PCWrite=1, IF_ID_Write=1, ID_EX_Bubble=0, IF_ID_Flush=ID_BranchTaken.
REQ-018 A stall SHALL suppress a branch flush; the branch is re-evaluated on the following cycle.
REQ-019 Countdown md_cnt (4 bits): when ID_MdStart=1 and stall=0, it SHALL load MD_LATENCY on the next edge; otherwise it SHALL decrement by 1 per cycle while nonzero and hold at 0.
REQ-020 MdBusy SHALL equal (md_cnt != 0); a start accepted in cycle N gives MdBusy=1 for cycles N+1..N+MD_LATENCY.
REQ-021 A start while busy is itself an md_hazard and SHALL NOT reload the countdown.

Reset
REQ-022 rst_n=0 SHALL clear md_cnt, and the stall counter when present, immediately; an in-flight multiply/divide countdown is abandoned.
REQ-023 During reset, outputs SHALL follow REQ-015..017 with MdBusy=0.

Configuration
REQ-024 With HAZARD_STALL_CNT_EN defined: the block SHALL have output StallCount, 32 bits, incremented on every edge with stall=1, wrapping at 2^32-1 to 0, reset to 0.
REQ-025 Without HAZARD_STALL_CNT_EN: the StallCount port and its counter SHALL be absent.

Structure
REQ-026 `LEN_INST_REG and a define for the countdown width SHALL come from defs.v.
REQ-027 The match function SHALL be implemented as one sub-module, reg_match, instantiated for the load_use, EX-branch and MEM-branch comparisons.

Verification
REQ-028 ID_EX_MemRead=1, ID_EX_Rd=8, ID_Rs=8 -> PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1 for exactly that cycle.
REQ-029 Same as REQ-028 with ID_EX_Rd=0, or with ID_Rt=8 and ID_UsesRt=0 -> no stall.
REQ-030 Branch reading r5 behind a lw r5 -> stall in cycles 1 and 2, then IF_ID_Flush=1 in cycle 3 if taken.
REQ-031 MD_LATENCY=4, mult accepted in cycle 0, mflo in ID in cycle 1 -> stall in cycles 1..4, released in cycle 5.
REQ-032 Reset asserted mid-countdown -> MdBusy=0 at once, no stall on the next mflo.
REQ-033 HAZARD_STALL_CNT_EN defined, counter preset near wrap, 3 stall cycles -> StallCount = 0xFFFFFFFF, 0, 1.

Source files
------------

// File: rtl/hazard_stall_unit_pkg.sv
// Types and helpers shared by the hazard/stall unit.
// Optional stall counter is enabled with HAZARD_STALL_CNT_EN.
`ifndef DEFS_V
`include "defs.v"
`endif

package hazard_stall_unit_pkg;

  localparam int REG_W = `LEN_INST_REG;
  localparam int CNT_W = `LEN_MD_CNT;

  typedef logic [REG_W-1:0] reg_idx_t;
  typedef logic [CNT_W-1:0] md_cnt_t;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic bubble;
    logic flush;
  } ctrl_t;

  // A stall freezes IF/ID and swallows any pending branch flush.
  function automatic ctrl_t ctrl_of(
    input logic stall,
    input logic taken
  );
    ctrl_t c;
    c.pc_write    = ~stall;
    c.if_id_write = ~stall;
    c.bubble      = stall;
    c.flush       = ~stall & taken;
    return c;
  endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Bundle of ID/EX/MEM hazard inputs and pipeline control outputs.
// master drives the pipeline state, slave is the hazard unit side.
interface hazard_stall_unit_if
  import hazard_stall_unit_pkg::*;
();

  reg_idx_t ID_Rs;
  reg_idx_t ID_Rt;
  logic     ID_UsesRt;
  logic     ID_Branch;
  logic     ID_ReadsHiLo;
  logic     ID_MdStart;
  logic     ID_EX_MemRead;
  logic     ID_EX_RegWrite;
  reg_idx_t ID_EX_Rd;
  logic     EX_MEM_MemRead;
  reg_idx_t EX_MEM_Rd;
  logic     ID_BranchTaken;
  logic     PCWrite;
  logic     IF_ID_Write;
  logic     ID_EX_Bubble;
  logic     IF_ID_Flush;
  logic     MdBusy;

  modport master (
    output ID_Rs, ID_Rt, ID_UsesRt,
    output ID_Branch, ID_ReadsHiLo,
    output ID_MdStart, ID_EX_MemRead,
    output ID_EX_RegWrite, ID_EX_Rd,
    output EX_MEM_MemRead, EX_MEM_Rd,
    output ID_BranchTaken,
    input  PCWrite, IF_ID_Write,
    input  ID_EX_Bubble, IF_ID_Flush,
    input  MdBusy
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRt,
    input  ID_Branch, ID_ReadsHiLo,
    input  ID_MdStart, ID_EX_MemRead,
    input  ID_EX_RegWrite, ID_EX_Rd,
    input  EX_MEM_MemRead, EX_MEM_Rd,
    input  ID_BranchTaken,
    output PCWrite, IF_ID_Write,
    output ID_EX_Bubble, IF_ID_Flush,
    output MdBusy
  );

endinterface

// File: rtl/defs.v
// Shared width defines for the hazard/stall block.
// Register index width and multiply/divide countdown width.
`ifndef DEFS_V
`define DEFS_V
`define LEN_INST_REG 5
`define LEN_MD_CNT 4
`endif

// File: rtl/hazard_stall_unit_reg_match.sv
// Destination-vs-source register match used by every hazard check.
// r0 never matches since it is never really written.
module reg_match
  import hazard_stall_unit_pkg::*;
(
  input  reg_idx_t dst,
  input  reg_idx_t rs,
  input  reg_idx_t rt,
  input  logic     uses_rt,
  output logic     hit
);

  assign hit = (dst != '0) &&
               ((dst == rs) ||
                (uses_rt && (dst == rt)));

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use, branch and mul/div hazard detection with pipeline stall control.
// Define HAZARD_STALL_CNT_EN to add the 32-bit StallCount output.
`ifndef DEFS_V
`include "defs.v"
`endif

module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int MD_LATENCY = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [`LEN_INST_REG-1:0] ID_Rs,
  input  logic [`LEN_INST_REG-1:0] ID_Rt,
  input  logic                     ID_UsesRt,
  input  logic                     ID_Branch,
  input  logic                     ID_ReadsHiLo,
  input  logic                     ID_MdStart,
  input  logic                     ID_EX_MemRead,
  input  logic                     ID_EX_RegWrite,
  input  logic [`LEN_INST_REG-1:0] ID_EX_Rd,
  input  logic                     EX_MEM_MemRead,
  input  logic [`LEN_INST_REG-1:0] EX_MEM_Rd,
  input  logic                     ID_BranchTaken,
  output logic                     PCWrite,
  output logic                     IF_ID_Write,
  output logic                     ID_EX_Bubble,
  output logic                     IF_ID_Flush,
  output logic                     MdBusy
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0]              StallCount
`endif
);

  localparam md_cnt_t MD_LOAD = md_cnt_t'(MD_LATENCY);

  logic    ex_hit;
  logic    mem_hit;
  logic    load_use;
  logic    br_hazard;
  logic    md_hazard;
  logic    stall;
  ctrl_t   ctrl;
  md_cnt_t md_cnt;

  reg_match u_ex_match (
    .dst     (ID_EX_Rd),
    .rs      (ID_Rs),
    .rt      (ID_Rt),
    .uses_rt (ID_UsesRt),
    .hit     (ex_hit)
  );

  reg_match u_mem_match (
    .dst     (EX_MEM_Rd),
    .rs      (ID_Rs),
    .rt      (ID_Rt),
    .uses_rt (ID_UsesRt),
    .hit     (mem_hit)
  );

  assign load_use  = ID_EX_MemRead & ex_hit;
  assign br_hazard = ID_Branch &
                     ((ID_EX_RegWrite & ex_hit) |
                      (EX_MEM_MemRead & mem_hit));
  assign md_hazard = MdBusy &
                     (ID_ReadsHiLo | ID_MdStart);
  assign stall     = load_use | br_hazard | md_hazard;

  assign ctrl         = ctrl_of(stall, ID_BranchTaken);
  assign PCWrite      = ctrl.pc_write;
  assign IF_ID_Write  = ctrl.if_id_write;
  assign ID_EX_Bubble = ctrl.bubble;
  assign IF_ID_Flush  = ctrl.flush;
  assign MdBusy       = (md_cnt != '0);

  // A start seen while busy is stalled, so it never reloads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt <= '0;
    end else if (ID_MdStart && !stall) begin
      md_cnt <= MD_LOAD;
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - md_cnt_t'(1);
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCount <= '0;
    end else if (stall) begin
      StallCount <= StallCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed scoreboard bench for hazard_stall_unit.
// Covers StallCount wrap only when HAZARD_STALL_CNT_EN is defined.
module tb_hazard_stall_unit;
  import hazard_stall_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  hazard_stall_unit_if bus ();

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_count;
`endif

  hazard_stall_unit #(.MD_LATENCY(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ID_Rs          (bus.ID_Rs),
    .ID_Rt          (bus.ID_Rt),
    .ID_UsesRt      (bus.ID_UsesRt),
    .ID_Branch      (bus.ID_Branch),
    .ID_ReadsHiLo   (bus.ID_ReadsHiLo),
    .ID_MdStart     (bus.ID_MdStart),
    .ID_EX_MemRead  (bus.ID_EX_MemRead),
    .ID_EX_RegWrite (bus.ID_EX_RegWrite),
    .ID_EX_Rd       (bus.ID_EX_Rd),
    .EX_MEM_MemRead (bus.EX_MEM_MemRead),
    .EX_MEM_Rd      (bus.EX_MEM_Rd),
    .ID_BranchTaken (bus.ID_BranchTaken),
    .PCWrite        (bus.PCWrite),
    .IF_ID_Write    (bus.IF_ID_Write),
    .ID_EX_Bubble   (bus.ID_EX_Bubble),
    .IF_ID_Flush    (bus.IF_ID_Flush),
    .MdBusy         (bus.MdBusy)
`ifdef HAZARD_STALL_CNT_EN
    ,
    .StallCount     (stall_count)
`endif
  );

  typedef struct {
    string       tag;
    logic [4:0]  exp;
  } item_t;

  item_t sb[$];
  int checks = 0;
  int fails = 0;

  // {PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, MdBusy}
  localparam logic [4:0] RUN   = 5'b11000;
  localparam logic [4:0] STALL = 5'b00100;
  localparam logic [4:0] FLUSH = 5'b11010;
  localparam logic [4:0] MDSTL = 5'b00101;
  localparam logic [4:0] MDRUN = 5'b11001;

  function automatic logic [4:0] observed();
    return {bus.PCWrite, bus.IF_ID_Write,
            bus.ID_EX_Bubble, bus.IF_ID_Flush,
            bus.MdBusy};
  endfunction

  task automatic clear();
    bus.ID_Rs          = '0;
    bus.ID_Rt          = '0;
    bus.ID_UsesRt      = 1'b0;
    bus.ID_Branch      = 1'b0;
    bus.ID_ReadsHiLo   = 1'b0;
    bus.ID_MdStart     = 1'b0;
    bus.ID_EX_MemRead  = 1'b0;
    bus.ID_EX_RegWrite = 1'b0;
    bus.ID_EX_Rd       = '0;
    bus.EX_MEM_MemRead = 1'b0;
    bus.EX_MEM_Rd      = '0;
    bus.ID_BranchTaken = 1'b0;
  endtask

  task automatic step(input string tag, input logic [4:0] e);
    item_t it;
    logic [4:0] obs;
    sb.push_back('{tag, e});
    @(negedge clk);
    while (sb.size() > 0) begin
      it = sb.pop_front();
      obs = observed();
      checks++;
      assert (obs === it.exp) else begin
        fails++;
        $error("FAIL %s: observed %b expected %b",
               it.tag, obs, it.exp);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    clear();
    rst_n = 1'b0;
    step("reset_idle", RUN);
    bus.ID_EX_MemRead = 1'b1;
    bus.ID_EX_Rd = 5'd8;
    bus.ID_Rs = 5'd8;
    step("reset_comb_stall", STALL);
    clear();
    rst_n = 1'b1;
    step("post_reset", RUN);

    bus.ID_EX_MemRead = 1'b1;
    bus.ID_EX_Rd = 5'd8;
    bus.ID_Rs = 5'd8;
    step("load_use_rs", STALL);
    clear();
    step("load_use_released", RUN);

    bus.ID_EX_MemRead = 1'b1;
    step("load_use_r0", RUN);
    bus.ID_EX_Rd = 5'd8;
    bus.ID_Rs = 5'd3;
    bus.ID_Rt = 5'd8;
    step("rt_unused", RUN);
    bus.ID_UsesRt = 1'b1;
    step("load_use_rt", STALL);
    clear();

    bus.ID_EX_RegWrite = 1'b1;
    bus.ID_EX_Rd = 5'd7;
    bus.ID_Rs = 5'd7;
    step("alu_no_branch", RUN);
    bus.ID_Branch = 1'b1;
    step("alu_to_branch", STALL);
    clear();
    bus.ID_Branch = 1'b1;
    bus.ID_Rs = 5'd9;
    bus.EX_MEM_Rd = 5'd9;
    step("mem_alu_branch", RUN);
    clear();

    bus.ID_Branch = 1'b1;
    bus.ID_BranchTaken = 1'b1;
    bus.ID_Rs = 5'd5;
    bus.ID_EX_MemRead = 1'b1;
    bus.ID_EX_RegWrite = 1'b1;
    bus.ID_EX_Rd = 5'd5;
    step("lw_branch_c1", STALL);
    bus.ID_EX_MemRead = 1'b0;
    bus.ID_EX_RegWrite = 1'b0;
    bus.ID_EX_Rd = '0;
    bus.EX_MEM_MemRead = 1'b1;
    bus.EX_MEM_Rd = 5'd5;
    step("lw_branch_c2", STALL);
    bus.EX_MEM_MemRead = 1'b0;
    bus.EX_MEM_Rd = '0;
    step("lw_branch_flush", FLUSH);
    clear();
    step("flush_clear", RUN);

    bus.ID_MdStart = 1'b1;
    step("mult_c0", RUN);
    bus.ID_MdStart = 1'b0;
    bus.ID_ReadsHiLo = 1'b1;
    step("mflo_c1", MDSTL);
    step("mflo_c2", MDSTL);
    step("mflo_c3", MDSTL);
    step("mflo_c4", MDSTL);
    step("mflo_c5", RUN);
    clear();

    bus.ID_MdStart = 1'b1;
    step("md_start_a", RUN);
    step("md_start_busy", MDSTL);
    bus.ID_MdStart = 1'b0;
    step("md_noreload_3", MDRUN);
    step("md_noreload_2", MDRUN);
    step("md_noreload_1", MDRUN);
    step("md_noreload_0", RUN);

    bus.ID_MdStart = 1'b1;
    step("md_start_b", RUN);
    bus.ID_MdStart = 1'b0;
    step("md_busy_b", MDRUN);
    rst_n = 1'b0;
    bus.ID_ReadsHiLo = 1'b1;
    step("reset_mid_md", RUN);
    rst_n = 1'b1;
    step("mflo_after_reset", RUN);
    clear();

`ifdef HAZARD_STALL_CNT_EN
    force dut.StallCount = 32'hFFFF_FFFE;
    #1;
    release dut.StallCount;
    bus.ID_EX_MemRead = 1'b1;
    bus.ID_EX_Rd = 5'd8;
    bus.ID_Rs = 5'd8;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] want;
      @(posedge clk);
      #1;
      want = 32'hFFFF_FFFF + 32'(i);
      checks++;
      assert (stall_count === want) else begin
        fails++;
        $error("FAIL stall_count_%0d: observed %h expected %h",
               i, stall_count, want);
      end
    end
    clear();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
